// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Types and constants shared by the instruction fetch slice.
//                Provides the fetch buffer entry layout {pc, inst} and the
//                fetch FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    // One fetch buffer entry; pc occupies the upper half of the packed word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of fetch_entry_t with a flush input.
//                Ports:
//                  clk, rst (sync, active-low)
//                  push, push_data   : enqueue an entry
//                  pop               : dequeue the head entry
//                  flush             : drop every entry, reset pointers;
//                                      overrides push and pop
//                  count, full, empty: occupancy
//                  head              : head entry, all-zero while empty
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 4,            // power of 2, at least 2
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Illegal requests are ignored; a full FIFO accepts a push only
    // alongside a pop, which frees the slot being written.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, drives the ROM
//                chip-enable/address, buffers {pc, inst} in a fetch FIFO and
//                hands entries to decode over a valid/ready handshake.
//                Redirects flush the buffer and reload the PC.
//                Ports:
//                  clk, rst (sync, active-low), fetch_en
//                  rom_ce, rom_addr, rom_inst        : instruction ROM
//                  redirect_valid, redirect_pc       : branch/jump/trap
//                  dec_valid, dec_ready, dec_pc,
//                  dec_inst                          : decode handshake
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN       = 32,   // must match core_pkg::XLEN
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4     // power of 2, at least 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            rom_ce,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_inst
);

    import core_pkg::*;

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    logic            run;
    logic            fetch;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_count;

    assign run = rst && (state_q == FS_RUN);

    // Outputs are forced low combinationally while rst is held, so nothing
    // leaks out before the first reset edge has cleared the state.
    assign dec_valid = rst && !fifo_empty;
    assign dec_pc    = dec_valid ? head.pc   : '0;
    assign dec_inst  = dec_valid ? head.inst : '0;
    assign pop       = dec_valid && dec_ready;

    // A full buffer may still fetch when decode pops in the same cycle;
    // this is the accepted dec_ready -> rom_ce combinational path.
    assign fetch    = run && !redirect_valid && (!fifo_full || pop);
    assign rom_ce   = fetch;
    assign rom_addr = run ? (pc_q & ALIGN_MASK) : '0;

    assign push_entry.pc   = pc_q;
    assign push_entry.inst = rom_inst;

    // Occupancy is tracked through full/empty only.
    assign unused_count = ^fifo_count;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            // Redirect keeps the FSM where it is and overrides everything else.
            pc_d = redirect_pc & ALIGN_MASK;
        end else begin
            if (fetch) pc_d = pc_q + XLEN'(INST_BYTES);
            case (state_q)
                FS_IDLE: if (fetch_en)  state_d = FS_RUN;
                FS_RUN:  if (!fetch_en) state_d = FS_IDLE;
                default: state_d = FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule : fetch_unit
`default_nettype wire
